serial_tx_unit: RTL and testbench

- Parallel-in, serial-out UART-style transmitter for calculator results.
- Sits downstream of the read/write flow controller:
  - Captures a result word on `p_load`.
  - Starts a framed serial transmission on `tx_dat`.
  - Reports idle/completion back to the controller on the `tx_done` level.
- Line format: start bit, `DATA_W` data bits LSB-first, optional parity bit, one stop bit.

---
 rtl/serial_tx_pkg.sv | 27 ++
 rtl/serial_tx_unit_baud_tick_gen.sv | 37 +++
 rtl/serial_tx_unit.sv | 150 +++++++++++++++
 tb/tb_serial_tx_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding and line levels.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds an even-parity bit before the stop bit).
package serial_tx_pkg;

    // State encoding values
    localparam logic [2:0] STATE_IDLE   = 3'd0;
    localparam logic [2:0] STATE_START  = 3'd1;
    localparam logic [2:0] STATE_DATA   = 3'd2;
    localparam logic [2:0] STATE_PARITY = 3'd3;
    localparam logic [2:0] STATE_STOP   = 3'd4;

    // Serial line levels
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        StIdle   = STATE_IDLE,
        StStart  = STATE_START,
        StData   = STATE_DATA,
`ifdef SERIAL_TX_PARITY_EN
        StParity = STATE_PARITY,
`endif
        StStop   = STATE_STOP
    } state_t;

endpackage

// File: rtl/serial_tx_unit_baud_tick_gen.sv
// Baud tick generator: one-cycle pulse every BAUD_DIV cycles, restartable by clr.
// The pulse is decoded from the counter register only, so it has no input path.
module baud_tick_gen #(
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on clr, wrap at the bit boundary
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/serial_tx_unit.sv
// UART-style parallel-in/serial-out transmitter: start bit, DATA_W data bits LSB-first,
// optional even parity (SERIAL_TX_PARITY_EN), one stop bit. tx_out/tx_done are registered.
module serial_tx_unit
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_load,
    input  logic              tx_dat,
    input  logic [DATA_W-1:0] din,
    output logic              tx_out,
    output logic              tx_done
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_done_q, tx_done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    logic              accept;
    logic              tick;

    assign accept = (state_q == StIdle) && tx_dat;

    baud_tick_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clr  (accept),
        .tick (tick)
    );

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_out_d  = tx_out_q;
        tx_done_d = tx_done_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (p_load) begin
                    hold_d = din;
                end
                if (tx_dat) begin
                    // Same-cycle load bypasses the holding register
                    shift_d   = p_load ? din : hold_q;
                    bit_cnt_d = '0;
                    tx_out_d  = START_BIT;
                    tx_done_d = 1'b0;
                    state_d   = StStart;
`ifdef SERIAL_TX_PARITY_EN
                    par_d     = 1'b0;
`endif
                end
            end
            StStart: begin
                if (tick) begin
                    tx_out_d  = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = par_q ^ shift_q[0];
`endif
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        tx_out_d = par_q ^ shift_q[0];
                        state_d  = StParity;
`else
                        tx_out_d = STOP_BIT;
                        state_d  = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_out_d  = shift_d[0];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    tx_out_d = STOP_BIT;
                    state_d  = StStop;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    tx_out_d  = LINE_IDLE;
                    tx_done_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                tx_out_d  = LINE_IDLE;
                tx_done_d = 1'b1;
                state_d   = StIdle;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_out_q  <= LINE_IDLE;
            tx_done_q <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_out_q  <= tx_out_d;
            tx_done_q <= tx_done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_serial_tx_unit.sv
// Self-checking bench for serial_tx_unit (DATA_W=8, BAUD_DIV=4) against a frame-level model.
module tb_serial_tx_unit;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned BAUD_DIV = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned NBITS = DATA_W + 3;
`else
    localparam int unsigned NBITS = DATA_W + 2;
`endif
    localparam int unsigned FL = NBITS * BAUD_DIV;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             p_load = 1'b0;
    logic             tx_dat = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic             tx_out;
    logic             tx_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] hold_m = '0;

    serial_tx_unit #(
        .DATA_W  (DATA_W),
        .BAUD_DIV(BAUD_DIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .p_load (p_load),
        .tx_dat (tx_dat),
        .din    (din),
        .tx_out (tx_out),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Line level for frame bit position idx: start, data LSB-first, [parity], stop
    function automatic logic model_bit(input logic [DATA_W-1:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= int'(DATA_W)) return d[idx-1];
`ifdef SERIAL_TX_PARITY_EN
        if (idx == int'(DATA_W) + 1) return logic'($countones(d) % 2);
`endif
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue tx_dat (optionally with p_load) and check the whole frame cycle by cycle.
    // inject >= 0 pulses p_load+tx_dat with 0xFF at that cycle offset within the frame.
    task automatic run_frame(input logic [DATA_W-1:0] d, input bit load, input int inject,
                             input string name);
        logic [DATA_W-1:0] exp_d;
        logic [FL-1:0]     obs, expw, done_obs;
        exp_d = load ? d : hold_m;
        if (load) hold_m = d;
        p_load = load;
        tx_dat = 1'b1;
        din    = d;
        step();
        p_load = 1'b0;
        tx_dat = 1'b0;
        for (int i = 0; i < int'(FL); i++) begin
            obs[i]      = tx_out;
            done_obs[i] = tx_done;
            expw[i]     = model_bit(exp_d, i / int'(BAUD_DIV));
            p_load = (i == inject);
            tx_dat = (i == inject);
            if (i == inject) din = 8'hFF;
            step();
        end
        p_load = 1'b0;
        tx_dat = 1'b0;
        n_cmp++;
        if (obs !== expw) begin
            n_err++;
            $display("FAIL %s line: got %h expected %h (data %h)", name, obs, expw, exp_d);
        end
        n_cmp++;
        if (done_obs !== '0) begin
            n_err++;
            $display("FAIL %s done_low: got %h expected 0", name, done_obs);
        end
        n_cmp++;
        if (tx_done !== 1'b1 || tx_out !== 1'b1) begin
            n_err++;
            $display("FAIL %s end_idle: got done=%b out=%b expected 1/1", name, tx_done, tx_out);
        end
    endtask

    // Check the line stays idle with done high for n cycles
    task automatic check_idle(input int n, input string name);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (tx_out !== 1'b1 || tx_done !== 1'b1) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL %s idle: got %0d non-idle cycles expected 0", name, bad);
        end
    endtask

    task automatic test_reset();
        step();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (tx_out !== 1'b1 || tx_done !== 1'b1) begin
            n_err++;
            $display("FAIL reset_async: got out=%b done=%b expected 1/1", tx_out, tx_done);
        end
        hold_m = '0;
        step();
        step();
        reset = 1'b0;
        check_idle(10, "reset_hold");
    endtask

    task automatic test_load_send();
        run_frame(8'hA5, 1'b1, -1, "load_send_a5");
    endtask

    task automatic test_held_data();
        p_load = 1'b1;
        din    = 8'h3C;
        step();
        hold_m = 8'h3C;
        p_load = 1'b0;
        din    = 8'hFF;
        for (int i = 0; i < 5; i++) step();
        run_frame(8'hFF, 1'b0, -1, "held_3c");
    endtask

    task automatic test_ignore_midframe();
        run_frame(8'h12, 1'b1, 14, "ignore_mid");
        check_idle(8, "no_second_frame");
        run_frame(8'h00, 1'b0, -1, "hold_still_12");
    endtask

    task automatic test_reset_midframe();
        p_load = 1'b1;
        tx_dat = 1'b1;
        din    = 8'h5A;
        step();
        p_load = 1'b0;
        tx_dat = 1'b0;
        // Move into data bit 3 (frame bit index 4)
        for (int i = 0; i < 17; i++) step();
        n_cmp++;
        if (tx_done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_frame_busy: got done=%b expected 0", tx_done);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (tx_out !== 1'b1 || tx_done !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_async: got out=%b done=%b expected 1/1", tx_out, tx_done);
        end
        hold_m = '0;
        step();
        reset = 1'b0;
        check_idle(8, "no_resume");
        run_frame(8'h81, 1'b1, -1, "after_reset_81");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            logic [DATA_W-1:0] d;
            bit ld;
            d  = DATA_W'($urandom);
            ld = bit'($urandom_range(0, 1));
            if (!ld && $urandom_range(0, 1) == 1) begin
                // Preload while idle, with a different din on the send cycle
                p_load = 1'b1;
                din    = d;
                step();
                hold_m = d;
                p_load = 1'b0;
                d      = ~d;
            end
            run_frame(d, ld, -1, "random_b2b");
        end
    endtask

    initial begin
        test_reset();
        test_load_send();
        test_held_data();
        test_ignore_midframe();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
